// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
// -----------------------------------------------------------------------------
// Shares one single-port RAM between the instruction-fetch path and the
// load/store path. A small IDLE/READ/WRITE machine arbitrates, drives the RAM
// address / read-write strobe / databus enable, and hands read data back to the
// owner of the access. It also produces the datapath steering signals
// (address-mux select, IR load pulse, load-data mux select) as registered
// outputs so the datapath no longer decodes them from the RAM strobe.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   fetch_req/addr      fetch request (held until fetch_gnt) and its address
//   fetch_gnt           one-cycle pulse: fetch accepted
//   fetch_valid/data    one-cycle pulse with the fetched instruction word
//   ir_load             IR load enable, same timing as fetch_valid
//   data_req/we/addr/   load/store request (held until data_gnt), 1 = store
//   data_wdata
//   data_gnt            one-cycle pulse: load/store accepted
//   data_valid/rdata    one-cycle pulse: load data valid or store complete;
//                       data_rdata holds its last loaded value otherwise
//   ldr_select          load-mux select, data_valid of a load only
//   adr_select          address-mux select, 0 = PC, 1 = data address
//   ram_addr            RAM address (follows fetch_addr while idle)
//   ram_rw              1 = write, 0 = read
//   ram_wdata/_oe       databus write value and its drive enable
//   ram_rdata           databus read value
// -----------------------------------------------------------------------------
module ram_access_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              ir_load,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ldr_select,
  output logic              adr_select,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Wait counter start value: READ lasts RAM_LAT cycles before capture.
  localparam logic [2:0] WAIT_INIT  = 3'(RAM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t              state_r, state_s;
  logic                owner_data_r, owner_data_s;   // 1 = load/store owns access
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic [2:0]          wait_r, wait_s;
  logic [3:0]          starve_r, starve_s;
  logic [3:0]          starve_inc_s;

  logic                grant_data_s, grant_fetch_s;

  logic                fetch_gnt_r, fetch_gnt_s;
  logic                fetch_valid_r, fetch_valid_s;
  logic [DATA_W-1:0]   fetch_data_r, fetch_data_s;
  logic                data_gnt_r, data_gnt_s;
  logic                data_valid_r, data_valid_s;
  logic [DATA_W-1:0]   data_rdata_r, data_rdata_s;
  logic                ldr_select_r, ldr_select_s;
  logic                adr_select_r, adr_select_s;
  logic                ram_rw_r, ram_rw_s;

  // Arbitration: data has priority until fetch has waited STARVE_LIM grants.
  always_comb begin
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    if (data_req && (!fetch_req || (starve_r != STARVE_MAX))) begin
      grant_data_s = 1'b1;
    end else if (fetch_req) begin
      grant_fetch_s = 1'b1;
    end else begin
      grant_fetch_s = 1'b0;
    end
  end

  // Saturating increment of the starvation counter.
  always_comb begin
    if (starve_r == STARVE_MAX) begin
      starve_inc_s = starve_r;
    end else begin
      starve_inc_s = starve_r + 4'd1;
    end
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_s       = state_r;
    owner_data_s  = owner_data_r;
    addr_s        = addr_r;
    wdata_s       = wdata_r;
    wait_s        = wait_r;
    starve_s      = starve_r;
    fetch_gnt_s   = 1'b0;
    fetch_valid_s = 1'b0;
    fetch_data_s  = fetch_data_r;
    data_gnt_s    = 1'b0;
    data_valid_s  = 1'b0;
    data_rdata_s  = data_rdata_r;
    ldr_select_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (grant_data_s) begin
          state_s      = data_we ? ST_WRITE : ST_READ;
          owner_data_s = 1'b1;
          addr_s       = data_addr;
          wdata_s      = data_wdata;
          wait_s       = WAIT_INIT;
          data_gnt_s   = 1'b1;
          // Only a grant that actually overtook a waiting fetch counts.
          starve_s     = fetch_req ? starve_inc_s : 4'd0;
        end else if (grant_fetch_s) begin
          state_s      = ST_READ;
          owner_data_s = 1'b0;
          addr_s       = fetch_addr;
          wait_s       = WAIT_INIT;
          fetch_gnt_s  = 1'b1;
          starve_s     = 4'd0;
        end else begin
          state_s      = ST_IDLE;
        end
      end
      ST_READ: begin
        if (wait_r == 3'd0) begin
          state_s = ST_IDLE;
          if (owner_data_r) begin
            data_rdata_s = ram_rdata;
            data_valid_s = 1'b1;
            ldr_select_s = 1'b1;
          end else begin
            fetch_data_s  = ram_rdata;
            fetch_valid_s = 1'b1;
          end
        end else begin
          wait_s = wait_r - 3'd1;
        end
      end
      ST_WRITE: begin
        state_s      = ST_IDLE;
        data_valid_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // RAM strobes and the address mux are registered from the next state,
    // so they line up exactly with the state they describe.
    ram_rw_s     = (state_s == ST_WRITE);
    adr_select_s = (state_s != ST_IDLE) && owner_data_s;
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      owner_data_r  <= 1'b0;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
      wait_r        <= 3'd0;
      starve_r      <= 4'd0;
      fetch_gnt_r   <= 1'b0;
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= {DATA_W{1'b0}};
      data_gnt_r    <= 1'b0;
      data_valid_r  <= 1'b0;
      data_rdata_r  <= {DATA_W{1'b0}};
      ldr_select_r  <= 1'b0;
      adr_select_r  <= 1'b0;
      ram_rw_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      owner_data_r  <= owner_data_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      wait_r        <= wait_s;
      starve_r      <= starve_s;
      fetch_gnt_r   <= fetch_gnt_s;
      fetch_valid_r <= fetch_valid_s;
      fetch_data_r  <= fetch_data_s;
      data_gnt_r    <= data_gnt_s;
      data_valid_r  <= data_valid_s;
      data_rdata_r  <= data_rdata_s;
      ldr_select_r  <= ldr_select_s;
      adr_select_r  <= adr_select_s;
      ram_rw_r      <= ram_rw_s;
    end
  end

  assign fetch_gnt    = fetch_gnt_r;
  assign fetch_valid  = fetch_valid_r;
  assign ir_load      = fetch_valid_r;
  assign fetch_data   = fetch_data_r;
  assign data_gnt     = data_gnt_r;
  assign data_valid   = data_valid_r;
  assign data_rdata   = data_rdata_r;
  assign ldr_select   = ldr_select_r;
  assign adr_select   = adr_select_r;
  assign ram_rw       = ram_rw_r;
  assign ram_wdata_oe = ram_rw_r;
  assign ram_wdata    = wdata_r;

  // Idle address tracks the PC so a fetch can start without a setup cycle;
  // held at zero while reset is asserted.
  assign ram_addr = (!reset) ? {ADDR_W{1'b0}}
                  : ((state_r == ST_IDLE) ? fetch_addr : addr_r);

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench for ram_access_sequencer. Three instances with RAM_LAT 1, 2
// and 3 share address/data inputs; each has its own request lines so only the
// instance under test is active. A behavioural RAM answers reads
// combinationally and takes writes on the clock edge ending a write cycle.
module tb_ram_access_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  fetch_req, data_req;
  logic [15:0] fetch_addr, data_addr;
  logic        data_we;
  logic [31:0] data_wdata;

  logic [2:0]  fetch_gnt, fetch_valid, ir_load, data_gnt, data_valid;
  logic [2:0]  ldr_select, adr_select, ram_rw, ram_wdata_oe;
  logic [31:0] fetch_data [3];
  logic [31:0] data_rdata [3];
  logic [15:0] ram_addr   [3];
  logic [31:0] ram_wdata  [3];
  logic [31:0] ram_rdata  [3];

  logic [31:0] mem [0:1023];

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata[0] = mem[ram_addr[0][9:0]];
  assign ram_rdata[1] = mem[ram_addr[1][9:0]];
  assign ram_rdata[2] = mem[ram_addr[2][9:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ram_rw[k] && ram_wdata_oe[k]) mem[ram_addr[k][9:0]] = ram_wdata[k];
    end
  end

  ram_access_sequencer #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(1), .STARVE_LIM(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt[0]),
    .fetch_valid(fetch_valid[0]), .fetch_data(fetch_data[0]), .ir_load(ir_load[0]),
    .data_req(data_req[0]), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt[0]), .data_valid(data_valid[0]), .data_rdata(data_rdata[0]),
    .ldr_select(ldr_select[0]), .adr_select(adr_select[0]), .ram_addr(ram_addr[0]),
    .ram_rw(ram_rw[0]), .ram_wdata(ram_wdata[0]), .ram_wdata_oe(ram_wdata_oe[0]),
    .ram_rdata(ram_rdata[0])
  );

  ram_access_sequencer #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(2), .STARVE_LIM(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt[1]),
    .fetch_valid(fetch_valid[1]), .fetch_data(fetch_data[1]), .ir_load(ir_load[1]),
    .data_req(data_req[1]), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt[1]), .data_valid(data_valid[1]), .data_rdata(data_rdata[1]),
    .ldr_select(ldr_select[1]), .adr_select(adr_select[1]), .ram_addr(ram_addr[1]),
    .ram_rw(ram_rw[1]), .ram_wdata(ram_wdata[1]), .ram_wdata_oe(ram_wdata_oe[1]),
    .ram_rdata(ram_rdata[1])
  );

  ram_access_sequencer #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(3), .STARVE_LIM(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req[2]), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt[2]),
    .fetch_valid(fetch_valid[2]), .fetch_data(fetch_data[2]), .ir_load(ir_load[2]),
    .data_req(data_req[2]), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt[2]), .data_valid(data_valid[2]), .data_rdata(data_rdata[2]),
    .ldr_select(ldr_select[2]), .adr_select(adr_select[2]), .ram_addr(ram_addr[2]),
    .ram_rw(ram_rw[2]), .ram_wdata(ram_wdata[2]), .ram_wdata_oe(ram_wdata_oe[2]),
    .ram_rdata(ram_rdata[2])
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({fetch_gnt[k], fetch_valid[k], ir_load[k], data_gnt[k], data_valid[k],
           ldr_select[k], adr_select[k], ram_rw[k], ram_wdata_oe[k]} !== 9'd0) begin
        tests_failed++;
        $display("FAIL reset_pulses dut%0d: got %b required 0", k,
                 {fetch_gnt[k], fetch_valid[k], ir_load[k], data_gnt[k], data_valid[k],
                  ldr_select[k], adr_select[k], ram_rw[k], ram_wdata_oe[k]});
      end
      tests_run++;
      if ({fetch_data[k], data_rdata[k], ram_wdata[k]} !== 96'd0) begin
        tests_failed++;
        $display("FAIL reset_data dut%0d: got %h %h %h required 0", k,
                 fetch_data[k], data_rdata[k], ram_wdata[k]);
      end
      tests_run++;
      if (ram_addr[k] !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_ram_addr dut%0d: got %h required 0000", k, ram_addr[k]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int gnt_at = 0;
    int val_at = 0;
    logic adr_seen = 1'b0;
    logic ir_bad = 1'b0;
    logic [31:0] fdata = 32'd0;
    logic [15:0] addr_rd = 16'd0;
    fetch_addr   = 16'h0004;
    fetch_req[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) addr_rd = ram_addr[0];
      if (fetch_valid[0]) begin val_at = c; fdata = fetch_data[0]; end
      if (ir_load[0] !== fetch_valid[0]) ir_bad = 1'b1;
      adr_seen = adr_seen | adr_select[0];
      if (fetch_gnt[0]) begin gnt_at = c; fetch_req[0] = 1'b0; end
    end
    fetch_req[0] = 1'b0;
    tests_run++;
    if (gnt_at !== 1) begin tests_failed++; $display("FAIL fetch_gnt_cycle: got %0d required 1", gnt_at); end
    tests_run++;
    if (val_at !== 2) begin tests_failed++; $display("FAIL fetch_valid_cycle: got %0d required 2", val_at); end
    tests_run++;
    if (fdata !== 32'hE1A00001) begin tests_failed++; $display("FAIL fetch_data: got %h required e1a00001", fdata); end
    tests_run++;
    if (adr_seen !== 1'b0) begin tests_failed++; $display("FAIL fetch_adr_select: got %b required 0", adr_seen); end
    tests_run++;
    if (ir_bad !== 1'b0) begin tests_failed++; $display("FAIL ir_load_match: got %b required 0", ir_bad); end
    tests_run++;
    if (addr_rd !== 16'h0004) begin tests_failed++; $display("FAIL fetch_ram_addr: got %h required 0004", addr_rd); end
  endtask

  task automatic test_store_load();
    int gnt_at = 0;
    int val_at = 0;
    int rw_cnt = 0;
    int oe_cnt = 0;
    logic ldr_any = 1'b0;
    logic ldr_at = 1'b0;
    logic adr_c1 = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd = 32'd0;
    logic [15:0] wa = 16'd0;
    // store
    data_addr = 16'h0100; data_wdata = 32'hDEADBEEF; data_we = 1'b1; data_req[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rw_cnt += int'(ram_rw[0]);
      oe_cnt += int'(ram_wdata_oe[0]);
      if (ram_rw[0]) begin wd = ram_wdata[0]; wa = ram_addr[0]; end
      ldr_any = ldr_any | ldr_select[0];
      if (data_valid[0]) val_at = c;
      if (data_gnt[0]) begin gnt_at = c; data_req[0] = 1'b0; end
    end
    data_req[0] = 1'b0;
    tests_run++;
    if (rw_cnt !== 1) begin tests_failed++; $display("FAIL store_rw_cycles: got %0d required 1", rw_cnt); end
    tests_run++;
    if (oe_cnt !== 1) begin tests_failed++; $display("FAIL store_oe_cycles: got %0d required 1", oe_cnt); end
    tests_run++;
    if ({wa, wd} !== {16'h0100, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL store_bus: got %h/%h required 0100/deadbeef", wa, wd);
    end
    tests_run++;
    if ({gnt_at, val_at} !== {32'd1, 32'd2}) begin
      tests_failed++; $display("FAIL store_timing: got gnt %0d valid %0d required 1 2", gnt_at, val_at);
    end
    tests_run++;
    if (ldr_any !== 1'b0) begin tests_failed++; $display("FAIL store_ldr_select: got %b required 0", ldr_any); end
    tests_run++;
    if (data_rdata[0] !== 32'd0) begin tests_failed++; $display("FAIL store_rdata_hold: got %h required 0", data_rdata[0]); end
    // load back
    val_at = 0; rw_cnt = 0;
    data_we = 1'b0; data_req[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rw_cnt += int'(ram_rw[0]);
      if (c == 1) adr_c1 = adr_select[0];
      if (data_valid[0]) begin val_at = c; rd = data_rdata[0]; ldr_at = ldr_select[0]; end
      if (data_gnt[0]) data_req[0] = 1'b0;
    end
    data_req[0] = 1'b0;
    tests_run++;
    if (val_at !== 2) begin tests_failed++; $display("FAIL load_valid_cycle: got %0d required 2", val_at); end
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rdata: got %h required deadbeef", rd); end
    tests_run++;
    if (ldr_at !== 1'b1) begin tests_failed++; $display("FAIL load_ldr_select: got %b required 1", ldr_at); end
    tests_run++;
    if (adr_c1 !== 1'b1) begin tests_failed++; $display("FAIL load_adr_select: got %b required 1", adr_c1); end
    tests_run++;
    if (rw_cnt !== 0) begin tests_failed++; $display("FAIL load_rw_cycles: got %0d required 0", rw_cnt); end
    tests_run++;
    if (data_rdata[0] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rdata_hold: got %h required deadbeef", data_rdata[0]); end
  endtask

  task automatic test_simultaneous();
    int dg = 0, dv = 0, fg = 0, fv = 0;
    logic adr_dg = 1'b0, adr_fg = 1'b1;
    logic [31:0] dd = 32'd0, fd = 32'd0;
    fetch_addr = 16'h0008; data_addr = 16'h0020; data_we = 1'b0;
    fetch_req[0] = 1'b1; data_req[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (data_valid[0]) begin dv = c; dd = data_rdata[0]; end
      if (fetch_valid[0]) begin fv = c; fd = fetch_data[0]; end
      if (data_gnt[0]) begin dg = c; adr_dg = adr_select[0]; data_req[0] = 1'b0; end
      if (fetch_gnt[0]) begin fg = c; adr_fg = adr_select[0]; fetch_req[0] = 1'b0; end
    end
    fetch_req[0] = 1'b0; data_req[0] = 1'b0;
    tests_run++;
    if ({dg, dv} !== {32'd1, 32'd2}) begin
      tests_failed++; $display("FAIL sim_data_timing: got gnt %0d valid %0d required 1 2", dg, dv);
    end
    tests_run++;
    if (adr_dg !== 1'b1) begin tests_failed++; $display("FAIL sim_data_adr_select: got %b required 1", adr_dg); end
    tests_run++;
    if (dd !== 32'h11112222) begin tests_failed++; $display("FAIL sim_data_rdata: got %h required 11112222", dd); end
    tests_run++;
    if ({fg, fv} !== {32'd3, 32'd4}) begin
      tests_failed++; $display("FAIL sim_fetch_timing: got gnt %0d valid %0d required 3 4", fg, fv);
    end
    tests_run++;
    if (adr_fg !== 1'b0) begin tests_failed++; $display("FAIL sim_fetch_adr_select: got %b required 0", adr_fg); end
    tests_run++;
    if (fd !== 32'h33334444) begin tests_failed++; $display("FAIL sim_fetch_data: got %h required 33334444", fd); end
  endtask

  task automatic test_starvation();
    logic [9:0] seq = 10'd0;
    int n = 0;
    logic [3:0] max_st = 4'd0;
    fetch_addr = 16'h0008; data_addr = 16'h0020; data_we = 1'b0;
    fetch_req[0] = 1'b1; data_req[0] = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (u_dut0.starve_r > max_st) max_st = u_dut0.starve_r;
      if (data_gnt[0])  begin seq = {seq[8:0], 1'b1}; n++; end
      if (fetch_gnt[0]) begin seq = {seq[8:0], 1'b0}; n++; end
      if (n >= 10) break;
    end
    fetch_req[0] = 1'b0; data_req[0] = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (n !== 10) begin tests_failed++; $display("FAIL starve_grant_count: got %0d required 10", n); end
    tests_run++;
    if (seq !== 10'b1111011110) begin tests_failed++; $display("FAIL starve_order: got %b required 1111011110", seq); end
    tests_run++;
    if (max_st > 4'd4) begin tests_failed++; $display("FAIL starve_cnt_max: got %0d required <=4", max_st); end
  endtask

  task automatic test_back_to_back();
    int ng = 0;
    int nv = 0;
    int vat [3] = '{0, 0, 0};
    logic [31:0] vd [3] = '{32'd0, 32'd0, 32'd0};
    fetch_addr = 16'h0000;
    fetch_req[1] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (fetch_valid[1]) begin
        if (nv < 3) begin vat[nv] = c; vd[nv] = fetch_data[1]; end
        nv++;
      end
      if (fetch_gnt[1]) begin
        ng++;
        if (ng < 3) fetch_addr = 16'(ng);
        else fetch_req[1] = 1'b0;
      end
    end
    fetch_req[1] = 1'b0;
    tests_run++;
    if (nv !== 3) begin tests_failed++; $display("FAIL b2b_valid_count: got %0d required 3", nv); end
    tests_run++;
    if ({vat[0], vat[1], vat[2]} !== {32'd3, 32'd6, 32'd9}) begin
      tests_failed++; $display("FAIL b2b_valid_cycles: got %0d %0d %0d required 3 6 9", vat[0], vat[1], vat[2]);
    end
    tests_run++;
    if ({vd[0], vd[1], vd[2]} !== {32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002}) begin
      tests_failed++; $display("FAIL b2b_data: got %h %h %h required a0a00000 a0a00001 a0a00002", vd[0], vd[1], vd[2]);
    end
  endtask

  task automatic test_reset_mid_read();
    int vcnt = 0;
    int rwcnt = 0;
    fetch_addr = 16'h0010;
    fetch_req[2] = 1'b1;
    @(negedge clk);
    tests_run++;
    if (fetch_gnt[2] !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_gnt: got %b required 1", fetch_gnt[2]); end
    fetch_req[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({fetch_gnt[2], fetch_valid[2], ir_load[2], data_gnt[2], data_valid[2],
         ldr_select[2], adr_select[2], ram_rw[2], ram_wdata_oe[2]} !== 9'd0) begin
      tests_failed++; $display("FAIL rst_mid_pulses: got nonzero required 0");
    end
    tests_run++;
    if ({ram_addr[2], fetch_data[2]} !== 48'd0) begin
      tests_failed++; $display("FAIL rst_mid_data: got %h %h required 0", ram_addr[2], fetch_data[2]);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b1;
      vcnt  += int'(fetch_valid[2] | ir_load[2]);
      rwcnt += int'(ram_rw[2]);
    end
    tests_run++;
    if (vcnt !== 0) begin tests_failed++; $display("FAIL rst_mid_no_valid: got %0d required 0", vcnt); end
    tests_run++;
    if (rwcnt !== 0) begin tests_failed++; $display("FAIL rst_mid_no_write: got %0d required 0", rwcnt); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b0;
    fetch_req = 3'd0; data_req = 3'd0;
    fetch_addr = 16'd0; data_addr = 16'd0; data_we = 1'b0; data_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
    mem[0]     = 32'hA0A0_0000;
    mem[1]     = 32'hA0A0_0001;
    mem[2]     = 32'hA0A0_0002;
    mem[4]     = 32'hE1A0_0001;
    mem[8]     = 32'h3333_4444;
    mem[16]    = 32'h7777_1010;
    mem[32]    = 32'h1111_2222;
    mem[256]   = 32'h0000_0000;

    test_reset();
    test_single_fetch();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
